forward_select_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 28 ++
 rtl/fwd_operand_cmp.sv | 52 +++++
 rtl/forward_select_unit.sv | 125 ++++++++++++
 tb/tb_forward_select_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the execute-stage bypass controller: operand-select
// codes, tracker entry layout and a small helper for the MEM/WB code choice.
package fwd_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_RF         = 3'b000;
    localparam logic [SEL_W-1:0] SEL_EXMEM_ALU  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_MEMWB_ALU  = 3'b010;
    localparam logic [SEL_W-1:0] SEL_MEMWB_LOAD = 3'b011;
    localparam logic [SEL_W-1:0] SEL_WB_HOLD    = 3'b100;
    localparam logic [SEL_W-1:0] SEL_PC_IMM     = 3'b101;

    // One in-flight instruction as seen by the bypass logic.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             load;
    } trk_entry_t;

    // A producer two ahead delivers either its ALU result or its load data.
    function automatic logic [SEL_W-1:0] memwb_code(input logic is_load);
        return is_load ? SEL_MEMWB_LOAD : SEL_MEMWB_ALU;
    endfunction

endpackage

// File: rtl/fwd_operand_cmp.sv
// Match/priority logic for one ALU operand: compares the decode source
// specifier against the three tracked producers, picks the youngest match
// and flags a load-use hazard when that youngest producer is a load in EX.
module fwd_operand_cmp
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             rs_used,
    input  logic             override,
    input  logic             s1_valid,
    input  logic [REG_W-1:0] s1_rd,
    input  logic             s1_wr,
    input  logic             s1_load,
    input  logic             s2_valid,
    input  logic [REG_W-1:0] s2_rd,
    input  logic             s2_wr,
    input  logic             s2_load,
    input  logic             s3_valid,
    input  logic [REG_W-1:0] s3_rd,
    input  logic             s3_wr,
    output logic [SEL_W-1:0] sel,
    output logic             load_hazard
);

    logic rs_live;
    logic match_s1;
    logic match_s2;
    logic match_s3;

    // x0 is hard-wired zero, so it is never a forwarding or stall source.
    assign rs_live  = rs_used & (rs != '0);
    assign match_s1 = rs_live & s1_valid & s1_wr & (s1_rd == rs);
    assign match_s2 = rs_live & s2_valid & s2_wr & (s2_rd == rs);
    assign match_s3 = rs_live & s3_valid & s3_wr & (s3_rd == rs);

    assign load_hazard = match_s1 & s1_load;

    // Youngest producer wins; PC/immediate override bypasses everything.
    always_comb begin
        sel = SEL_RF;
        if (override) begin
            sel = SEL_PC_IMM;
        end else if (match_s1) begin
            sel = SEL_EXMEM_ALU;
        end else if (match_s2) begin
            sel = memwb_code(s2_load);
        end else if (match_s3) begin
            sel = SEL_WB_HOLD;
        end
    end

endmodule

// File: rtl/forward_select_unit.sv
// Execute-stage bypass controller. Tracks the destinations of the three
// instructions ahead of decode, registers the operand-select codes for the
// instruction entering EX and requests a one-cycle decode stall on load-use.
module forward_select_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_W,
    parameter int SEL_WIDTH      = SEL_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      PIPE_ADVANCE,
    input  logic                      FLUSH,
    input  logic                      ID_VALID,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RS1,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RS2,
    input  logic                      ID_RS1_USED,
    input  logic                      ID_RS2_USED,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RD,
    input  logic                      ID_RD_WRITE,
    input  logic                      ID_IS_LOAD,
    input  logic                      ID_USE_PC,
    input  logic                      ID_USE_IMM,
    output logic [SEL_WIDTH-1:0]      SEL_A,
    output logic [SEL_WIDTH-1:0]      SEL_B,
    output logic                      EX_VALID,
    output logic                      STALL
);

    // Tracker: EX and MEM keep the full entry, WB never needs the load flag.
    trk_entry_t       ex_p1;
    trk_entry_t       mem_p2;
    logic             wb_valid_p3;
    logic [REG_W-1:0] wb_rd_p3;
    logic             wb_wr_p3;

    logic [SEL_WIDTH-1:0] sel_a_p1;
    logic [SEL_WIDTH-1:0] sel_b_p1;

    trk_entry_t       id_entry_p0;
    logic [SEL_W-1:0] sel_a_p0;
    logic [SEL_W-1:0] sel_b_p0;
    logic             haz_a_p0;
    logic             haz_b_p0;
    logic             issue_p0;

    // ---- decode stage (p0): compare against tracker as it stands ----
    assign id_entry_p0 = '{valid: 1'b1, rd: ID_RD, wr: ID_RD_WRITE, load: ID_IS_LOAD};

    fwd_operand_cmp u_cmp_a (
        .rs          (ID_RS1),
        .rs_used     (ID_RS1_USED),
        .override    (ID_USE_PC),
        .s1_valid    (ex_p1.valid),
        .s1_rd       (ex_p1.rd),
        .s1_wr       (ex_p1.wr),
        .s1_load     (ex_p1.load),
        .s2_valid    (mem_p2.valid),
        .s2_rd       (mem_p2.rd),
        .s2_wr       (mem_p2.wr),
        .s2_load     (mem_p2.load),
        .s3_valid    (wb_valid_p3),
        .s3_rd       (wb_rd_p3),
        .s3_wr       (wb_wr_p3),
        .sel         (sel_a_p0),
        .load_hazard (haz_a_p0)
    );

    // An immediate operand B never reads rs2, so it cannot cause a hazard.
    fwd_operand_cmp u_cmp_b (
        .rs          (ID_RS2),
        .rs_used     (ID_RS2_USED & ~ID_USE_IMM),
        .override    (ID_USE_IMM),
        .s1_valid    (ex_p1.valid),
        .s1_rd       (ex_p1.rd),
        .s1_wr       (ex_p1.wr),
        .s1_load     (ex_p1.load),
        .s2_valid    (mem_p2.valid),
        .s2_rd       (mem_p2.rd),
        .s2_wr       (mem_p2.wr),
        .s2_load     (mem_p2.load),
        .s3_valid    (wb_valid_p3),
        .s3_rd       (wb_rd_p3),
        .s3_wr       (wb_wr_p3),
        .sel         (sel_b_p0),
        .load_hazard (haz_b_p0)
    );

    // A flushed decode instruction is dead anyway, so it must not stall.
    assign STALL    = ID_VALID & ~FLUSH & (haz_a_p0 | haz_b_p0);
    assign issue_p0 = ID_VALID & ~STALL & ~FLUSH;

    // ---- EX/MEM/WB stages (p1..p3): shift tracker and capture select codes ----
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ex_p1.valid  <= 1'b0;
            mem_p2.valid <= 1'b0;
            wb_valid_p3  <= 1'b0;
            sel_a_p1     <= SEL_RF;
            sel_b_p1     <= SEL_RF;
        end else if (PIPE_ADVANCE) begin
            wb_valid_p3 <= mem_p2.valid;
            wb_rd_p3    <= mem_p2.rd;
            wb_wr_p3    <= mem_p2.wr;
            mem_p2      <= ex_p1;
            if (FLUSH) begin
                mem_p2.valid <= 1'b0;
            end
            if (issue_p0) begin
                ex_p1    <= id_entry_p0;
                sel_a_p1 <= sel_a_p0;
                sel_b_p1 <= sel_b_p0;
            end else begin
                ex_p1.valid <= 1'b0;
                sel_a_p1    <= SEL_RF;
                sel_b_p1    <= SEL_RF;
            end
        end
    end

    assign SEL_A    = sel_a_p1;
    assign SEL_B    = sel_b_p1;
    assign EX_VALID = ex_p1.valid;

endmodule

// File: tb/tb_forward_select_unit.sv
// Bench for forward_select_unit: directed scenarios followed by a random run,
// all checked against a distance-based reference model of the bypass rules.
module tb_forward_select_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PIPE_ADVANCE;
    logic       FLUSH;
    logic       ID_VALID;
    logic [4:0] ID_RS1;
    logic [4:0] ID_RS2;
    logic       ID_RS1_USED;
    logic       ID_RS2_USED;
    logic [4:0] ID_RD;
    logic       ID_RD_WRITE;
    logic       ID_IS_LOAD;
    logic       ID_USE_PC;
    logic       ID_USE_IMM;
    logic [2:0] SEL_A;
    logic [2:0] SEL_B;
    logic       EX_VALID;
    logic       STALL;

    forward_select_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .PIPE_ADVANCE (PIPE_ADVANCE),
        .FLUSH        (FLUSH),
        .ID_VALID     (ID_VALID),
        .ID_RS1       (ID_RS1),
        .ID_RS2       (ID_RS2),
        .ID_RS1_USED  (ID_RS1_USED),
        .ID_RS2_USED  (ID_RS2_USED),
        .ID_RD        (ID_RD),
        .ID_RD_WRITE  (ID_RD_WRITE),
        .ID_IS_LOAD   (ID_IS_LOAD),
        .ID_USE_PC    (ID_USE_PC),
        .ID_USE_IMM   (ID_USE_IMM),
        .SEL_A        (SEL_A),
        .SEL_B        (SEL_B),
        .EX_VALID     (EX_VALID),
        .STALL        (STALL)
    );

    always #5 CLK = ~CLK;

    // Reference model: ahead[d] is the instruction d slots ahead of decode.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } ment_t;

    ment_t    ahead [1:3];
    bit [2:0] exp_a;
    bit [2:0] exp_b;
    bit       exp_v;
    int       checks = 0;
    int       errors = 0;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, req);
        end
    endtask

    function automatic bit writes(int d, int rs);
        return ahead[d].v && ahead[d].wr && ahead[d].rd == rs && rs != 0;
    endfunction

    // Nearest producer decides; its distance sets the code.
    function automatic bit [2:0] ref_sel(int rs, bit used, bit ovr);
        if (ovr) return 3'd5;
        if (!used) return 3'd0;
        for (int d = 1; d <= 3; d++) begin
            if (writes(d, rs)) begin
                if (d == 1) return 3'd1;
                if (d == 2) return ahead[2].ld ? 3'd3 : 3'd2;
                return 3'd4;
            end
        end
        return 3'd0;
    endfunction

    function automatic bit ref_stall();
        bit a_h;
        bit b_h;
        if (!ID_VALID || FLUSH) return 1'b0;
        a_h = ID_RS1_USED && writes(1, int'(ID_RS1)) && ahead[1].ld;
        b_h = ID_RS2_USED && !ID_USE_IMM && writes(1, int'(ID_RS2)) && ahead[1].ld;
        return a_h || b_h;
    endfunction

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit wr, input bit ld, input bit pc, input bit imm);
        ID_VALID    = v;
        ID_RS1      = rs1[4:0];
        ID_RS1_USED = u1;
        ID_RS2      = rs2[4:0];
        ID_RS2_USED = u2;
        ID_RD       = rd[4:0];
        ID_RD_WRITE = wr;
        ID_IS_LOAD  = ld;
        ID_USE_PC   = pc;
        ID_USE_IMM  = imm;
    endtask

    // One clock: check STALL before the edge, then outputs after it.
    task automatic cyc(input bit adv, input bit fl);
        bit       st;
        bit [2:0] na;
        bit [2:0] nb;
        ment_t    ne;
        PIPE_ADVANCE = adv;
        FLUSH        = fl;
        #1;
        st = ref_stall();
        chk("stall", {2'b0, STALL}, {2'b0, st});
        na = ref_sel(int'(ID_RS1), ID_RS1_USED, ID_USE_PC);
        nb = ref_sel(int'(ID_RS2), ID_RS2_USED, ID_USE_IMM);
        ne = '{v: 1'b1, rd: int'(ID_RD), wr: ID_RD_WRITE, ld: ID_IS_LOAD};
        @(posedge CLK);
        if (!RST) begin
            for (int d = 1; d <= 3; d++) ahead[d].v = 1'b0;
            exp_a = 3'd0;
            exp_b = 3'd0;
            exp_v = 1'b0;
        end else if (adv) begin
            ahead[3] = ahead[2];
            ahead[2] = ahead[1];
            if (fl) ahead[2].v = 1'b0;
            if (ID_VALID && !st && !fl) begin
                ahead[1] = ne;
                exp_a    = na;
                exp_b    = nb;
                exp_v    = 1'b1;
            end else begin
                ahead[1].v = 1'b0;
                exp_a      = 3'd0;
                exp_b      = 3'd0;
                exp_v      = 1'b0;
            end
        end
        #1;
        chk("sel_a", SEL_A, exp_a);
        chk("sel_b", SEL_B, exp_b);
        chk("ex_valid", {2'b0, EX_VALID}, {2'b0, exp_v});
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0);
    endtask

    initial begin
        for (int d = 1; d <= 3; d++) ahead[d] = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        exp_a = 3'd0;
        exp_b = 3'd0;
        exp_v = 1'b0;

        // Reset held two cycles with a valid decode instruction present
        RST = 1'b0;
        PIPE_ADVANCE = 1'b1;
        FLUSH = 1'b0;
        set_id(1, 1, 1, 2, 1, 3, 1, 1, 0, 0);
        @(posedge CLK);
        #1;
        cyc(1, 0);
        chk("rst_sel_a", SEL_A, 3'd0);
        chk("rst_sel_b", SEL_B, 3'd0);
        chk("rst_ex_valid", {2'b0, EX_VALID}, 3'd0);
        chk("rst_stall", {2'b0, STALL}, 3'd0);
        RST = 1'b1;
        drain();

        // Back-to-back ALU: distance 1, 2, 3
        set_id(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); cyc(1, 0);
        set_id(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); cyc(1, 0);
        chk("d1_a", SEL_A, 3'd1);
        chk("d1_b", SEL_B, 3'd1);
        drain();
        set_id(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); cyc(1, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(1, 0);
        set_id(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); cyc(1, 0);
        chk("d2_a", SEL_A, 3'd2);
        chk("d2_b", SEL_B, 3'd2);
        drain();
        set_id(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); cyc(1, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(1, 0); cyc(1, 0);
        set_id(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); cyc(1, 0);
        chk("d3_a", SEL_A, 3'd4);
        chk("d3_b", SEL_B, 3'd4);
        drain();

        // Load-use: one stall cycle with a bubble, then MEM/WB load data
        set_id(1, 2, 1, 0, 0, 7, 1, 1, 0, 1); cyc(1, 0);
        set_id(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
        #1;
        chk("lu_stall", {2'b0, STALL}, 3'd1);
        cyc(1, 0);
        chk("lu_bubble", {2'b0, EX_VALID}, 3'd0);
        chk("lu_stall_gone", {2'b0, STALL}, 3'd0);
        cyc(1, 0);
        chk("lu_a", SEL_A, 3'd3);
        chk("lu_b", SEL_B, 3'd0);
        chk("lu_valid", {2'b0, EX_VALID}, 3'd1);
        drain();

        // Priority (youngest wins) and x0 never forwarding
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); cyc(1, 0);
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); cyc(1, 0);
        set_id(1, 3, 1, 0, 1, 9, 1, 0, 0, 0); cyc(1, 0);
        chk("prio_a", SEL_A, 3'd1);
        chk("prio_b", SEL_B, 3'd0);
        set_id(1, 1, 1, 2, 1, 0, 1, 1, 0, 0); cyc(1, 0);
        set_id(1, 0, 1, 0, 1, 10, 1, 0, 0, 0); cyc(1, 0);
        chk("x0_a", SEL_A, 3'd0);
        chk("x0_b", SEL_B, 3'd0);
        drain();

        // Overrides: immediate on B, PC on A
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); cyc(1, 0);
        set_id(1, 3, 1, 3, 1, 4, 1, 0, 0, 1); cyc(1, 0);
        chk("imm_a", SEL_A, 3'd1);
        chk("imm_b", SEL_B, 3'd5);
        set_id(1, 0, 0, 0, 0, 11, 1, 0, 1, 1); cyc(1, 0);
        chk("auipc_a", SEL_A, 3'd5);
        chk("auipc_b", SEL_B, 3'd5);
        drain();

        // Freeze and flush with a load-use pending
        set_id(1, 2, 1, 0, 0, 7, 1, 1, 0, 1); cyc(1, 0);
        set_id(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
        cyc(0, 0);
        chk("frz_valid", {2'b0, EX_VALID}, 3'd1);
        chk("frz_b", SEL_B, 3'd5);
        chk("frz_stall", {2'b0, STALL}, 3'd1);
        PIPE_ADVANCE = 1'b0;
        FLUSH = 1'b1;
        #1;
        chk("fl_stall", {2'b0, STALL}, 3'd0);
        cyc(1, 1);
        chk("fl_valid", {2'b0, EX_VALID}, 3'd0);
        set_id(1, 7, 1, 7, 1, 11, 1, 0, 0, 0); cyc(1, 0);
        chk("fl_kill_a", SEL_A, 3'd0);
        chk("fl_kill_b", SEL_B, 3'd0);
        drain();

        // Randomized traffic on a small register range to provoke matches
        for (int i = 0; i < 800; i++) begin
            RST = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            set_id($urandom_range(0, 9) < 8,
                   int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
